// File: rtl/periphery_pkg.sv
// Shared periphery definitions: perf-monitor command/state encodings, readout word map and
// channel indices.
package periphery_pkg;

  typedef enum logic [2:0] {
    PERF_OP_NOP   = 3'd0,
    PERF_OP_START = 3'd1,
    PERF_OP_STOP  = 3'd2,
    PERF_OP_CLEAR = 3'd3,
    PERF_OP_READ  = 3'd4
  } perf_op_e;

  typedef enum logic [1:0] {
    PERF_IDLE = 2'd0,
    PERF_RUN  = 2'd1,
    PERF_DONE = 2'd2
  } perf_state_e;

  // Counter slots double as readout word indices 0..4.
  localparam int unsigned PERF_WORD_REQ    = 0;
  localparam int unsigned PERF_WORD_GNT    = 1;
  localparam int unsigned PERF_WORD_STALL  = 2;
  localparam int unsigned PERF_WORD_AGG    = 3;
  localparam int unsigned PERF_WORD_CYC    = 4;
  localparam int unsigned PERF_WORD_STATUS = 5;
  localparam int unsigned PERF_WORD_RAW    = 6;
  localparam int unsigned PERF_N_CNT       = 5;

  localparam int unsigned PERF_CH_GLOBAL_RD    = 0;
  localparam int unsigned PERF_CH_GLOBAL_WR    = 1;
  localparam int unsigned PERF_CH_INSTR_STREAM = 2;
  localparam int unsigned PERF_CH_LD_STREAM    = 3;
  localparam int unsigned PERF_CH_ST_STREAM    = 4;

endpackage

// File: rtl/io_perf_monitor_if.sv
// Command, sampled req/gnt vectors and readout bundle of the IO performance monitor.
interface io_perf_monitor_if
  import periphery_pkg::*;
#(
  parameter int unsigned N_PE   = 64,
  parameter int unsigned N_CH   = 5,
  parameter int unsigned DATA_L = 32,
  parameter int unsigned WIN_L  = 16
) ();
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned PE_W = (N_PE > 1) ? $clog2(N_PE) : 1;

  logic                         cmd_vld;
  perf_op_e                     cmd_op;
  logic [CH_W-1:0]              cmd_ch;
  logic [PE_W-1:0]              cmd_pe;
  logic [WIN_L-1:0]             cmd_win;
  logic [7:0]                   cmd_word;
  logic [N_CH-1:0][N_PE-1:0]    req;
  logic [N_CH-1:0][N_PE-1:0]    gnt;
  logic [DATA_L-1:0]            out;
  logic                         out_vld;
  logic                         busy;
  logic                         done;

  modport master (
    output cmd_vld, cmd_op, cmd_ch, cmd_pe, cmd_win, cmd_word, req, gnt,
    input  out, out_vld, busy, done
  );

  modport slave (
    input  cmd_vld, cmd_op, cmd_ch, cmd_pe, cmd_win, cmd_word, req, gnt,
    output out, out_vld, busy, done
  );

endinterface

// File: rtl/perf_popcount.sv
// Combinational population count of an N-bit vector.
module perf_popcount #(
  parameter int unsigned N  = 64,
  parameter int unsigned CW = $clog2(N) + 1
) (
  input  logic [N-1:0]  vec,
  output logic [CW-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cnt = cnt + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/io_perf_monitor.sv
// Windowed req/gnt event counters for one selected channel/PE with registered word readout.
// Build option: IO_PERF_MONITOR_SATURATE_EN makes counters saturate instead of wrapping.
module io_perf_monitor
  import periphery_pkg::*;
#(
  parameter int unsigned N_PE   = 64,
  parameter int unsigned N_CH   = 5,
  parameter int unsigned DATA_L = 32,
  parameter int unsigned CNT_L  = 32,
  parameter int unsigned WIN_L  = 16
) (
  input logic              clk,
  input logic              rst,
  io_perf_monitor_if.slave bus
);

  localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned PE_W  = (N_PE > 1) ? $clog2(N_PE) : 1;
  localparam int unsigned PC_W  = $clog2(N_PE) + 1;
  localparam int unsigned N_RAW = N_PE / DATA_L;

  perf_state_e                          state_q, state_d;
  logic [CH_W-1:0]                      ch_q, ch_d;
  logic [PE_W-1:0]                      pe_q, pe_d;
  logic [WIN_L-1:0]                     win_q, win_d;
  logic [WIN_L-1:0]                     win_cnt_q, win_cnt_d;
  logic [PERF_N_CNT-1:0][CNT_L-1:0]     cnt_q, cnt_d, cnt_upd;
  logic [PERF_N_CNT-1:0]                ovf_q, ovf_d, carry;
  logic [PERF_N_CNT-1:0][PC_W-1:0]      inc;
  logic [DATA_L-1:0]                    out_q, rd_data;
  logic                                 out_vld_q;

  logic cmd_start, cmd_stop, cmd_clear, cmd_read;
  assign cmd_start = bus.cmd_vld && (bus.cmd_op == PERF_OP_START);
  assign cmd_stop  = bus.cmd_vld && (bus.cmd_op == PERF_OP_STOP);
  assign cmd_clear = bus.cmd_vld && (bus.cmd_op == PERF_OP_CLEAR);
  assign cmd_read  = bus.cmd_vld && (bus.cmd_op == PERF_OP_READ);

  logic [N_PE-1:0] req_vec, gnt_vec;
  logic            req_bit, gnt_bit;
  logic [PC_W-1:0] gnt_pop;

  assign req_vec = bus.req[ch_q];
  assign gnt_vec = bus.gnt[ch_q];
  assign req_bit = req_vec[pe_q];
  assign gnt_bit = gnt_vec[pe_q];

  perf_popcount #(
    .N  (N_PE),
    .CW (PC_W)
  ) u_popcount (
    .vec (gnt_vec),
    .cnt (gnt_pop)
  );

  always_comb begin
    inc                  = '0;
    inc[PERF_WORD_REQ]   = PC_W'(req_bit);
    inc[PERF_WORD_GNT]   = PC_W'(gnt_bit);
    inc[PERF_WORD_STALL] = PC_W'(req_bit & ~gnt_bit);
    inc[PERF_WORD_AGG]   = gnt_pop;
    inc[PERF_WORD_CYC]   = PC_W'(1);
  end

  // One extra sum bit captures the carry-out that feeds the sticky overflow flag.
  for (genvar i = 0; i < PERF_N_CNT; i++) begin : g_cnt
    logic [CNT_L:0] sum;
    assign sum      = {1'b0, cnt_q[i]} + (CNT_L+1)'(inc[i]);
    assign carry[i] = sum[CNT_L];
`ifdef IO_PERF_MONITOR_SATURATE_EN
    assign cnt_upd[i] = sum[CNT_L] ? {CNT_L{1'b1}} : sum[CNT_L-1:0];
`else
    assign cnt_upd[i] = sum[CNT_L-1:0];
`endif
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    pe_d      = pe_q;
    win_d     = win_q;
    win_cnt_d = win_cnt_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      PERF_IDLE, PERF_DONE: begin
        if (cmd_start) begin
          state_d   = PERF_RUN;
          ch_d      = bus.cmd_ch;
          pe_d      = bus.cmd_pe;
          win_d     = bus.cmd_win;
          win_cnt_d = '0;
          cnt_d     = '0;
          ovf_d     = '0;
        end
      end
      PERF_RUN: begin
        if (cmd_stop) begin
          state_d = PERF_DONE;
        end else begin
          cnt_d     = cnt_upd;
          ovf_d     = ovf_q | carry;
          win_cnt_d = win_cnt_q + WIN_L'(1);
          if ((win_q != '0) && (win_cnt_q == win_q - WIN_L'(1))) begin
            state_d = PERF_DONE;
          end
        end
      end
      default: state_d = PERF_IDLE;
    endcase
    if (cmd_clear) begin
      state_d   = PERF_IDLE;
      win_cnt_d = '0;
      cnt_d     = '0;
      ovf_d     = '0;
    end
  end

  // Readout reflects this cycle's update so a READ during RUN sees the live count.
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < PERF_N_CNT; i++) begin
      if (32'(bus.cmd_word) == i) rd_data = DATA_L'(cnt_d[i]);
    end
    if (32'(bus.cmd_word) == PERF_WORD_STATUS) rd_data = DATA_L'({ovf_d, state_d});
    for (int unsigned k = 0; k < N_RAW; k++) begin
      if (32'(bus.cmd_word) == PERF_WORD_RAW + k) rd_data = req_vec[k*DATA_L +: DATA_L];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= PERF_IDLE;
      ch_q      <= '0;
      pe_q      <= '0;
      win_q     <= '0;
      win_cnt_q <= '0;
      cnt_q     <= '0;
      ovf_q     <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      pe_q      <= pe_d;
      win_q     <= win_d;
      win_cnt_q <= win_cnt_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      out_vld_q <= cmd_read;
      if (cmd_read) out_q <= rd_data;
    end
  end

  assign bus.out     = out_q;
  assign bus.out_vld = out_vld_q;
  assign bus.busy    = (state_q == PERF_RUN);
  assign bus.done    = (state_q == PERF_DONE);

endmodule

// File: tb/tb_io_perf_monitor.sv
// Randomized and directed checks of io_perf_monitor (32-bit and 8-bit counter builds) against a
// transaction-level model holding unbounded true event counts.
module tb_io_perf_monitor;
  import periphery_pkg::*;

  localparam int unsigned N_PE   = 64;
  localparam int unsigned N_CH   = 5;
  localparam int unsigned DATA_L = 32;
  localparam int unsigned WIN_L  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  io_perf_monitor_if #(.N_PE(N_PE), .N_CH(N_CH), .DATA_L(DATA_L), .WIN_L(WIN_L)) bus ();
  io_perf_monitor_if #(.N_PE(N_PE), .N_CH(N_CH), .DATA_L(DATA_L), .WIN_L(WIN_L)) bus8 ();

  io_perf_monitor #(
    .N_PE(N_PE), .N_CH(N_CH), .DATA_L(DATA_L), .CNT_L(32), .WIN_L(WIN_L)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  io_perf_monitor #(
    .N_PE(N_PE), .N_CH(N_CH), .DATA_L(DATA_L), .CNT_L(8), .WIN_L(WIN_L)
  ) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  assign bus8.cmd_vld  = bus.cmd_vld;
  assign bus8.cmd_op   = bus.cmd_op;
  assign bus8.cmd_ch   = bus.cmd_ch;
  assign bus8.cmd_pe   = bus.cmd_pe;
  assign bus8.cmd_win  = bus.cmd_win;
  assign bus8.cmd_word = bus.cmd_word;
  assign bus8.req      = bus.req;
  assign bus8.gnt      = bus.gnt;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: 0 idle, 1 run, 2 done; counts kept unbounded and reduced per width on use.
  int                m_state;
  int unsigned       m_ch, m_pe, m_win;
  longint unsigned   m_cnt [5];
  logic [DATA_L-1:0] m_out, m_out8;
  bit                m_vld;
  logic [N_PE-1:0]   req_v [N_CH];
  logic [N_PE-1:0]   gnt_v [N_CH];

  function automatic longint unsigned cnt_exp(input longint unsigned v, input int cw);
    longint unsigned lim = 64'd1 << cw;
`ifdef IO_PERF_MONITOR_SATURATE_EN
    return (v >= lim) ? lim - 1 : v;
`else
    return v % lim;
`endif
  endfunction

  function automatic logic [DATA_L-1:0] word_exp(input int unsigned w, input int cw);
    logic [4:0] ov;
    logic [1:0] st;
    if (w < 5) return DATA_L'(cnt_exp(m_cnt[w], cw));
    if (w == 5) begin
      for (int i = 0; i < 5; i++) ov[i] = (m_cnt[i] >= (64'd1 << cw));
      st = 2'(m_state);
      return DATA_L'({ov, st});
    end
    if (w == 6 || w == 7) return req_v[m_ch][(w-6)*DATA_L +: DATA_L];
    return '0;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_ch = 0; m_pe = 0; m_win = 0;
    for (int i = 0; i < 5; i++) m_cnt[i] = 0;
    m_out = '0; m_out8 = '0; m_vld = 1'b0;
  endtask

  task automatic step(input bit vld, input perf_op_e op, input int unsigned ch,
                      input int unsigned pe, input int unsigned win, input int unsigned word);
    @(negedge clk);
    bus.cmd_vld  = vld;
    bus.cmd_op   = op;
    bus.cmd_ch   = 3'(ch);
    bus.cmd_pe   = 6'(pe);
    bus.cmd_win  = 16'(win);
    bus.cmd_word = 8'(word);
    for (int c = 0; c < N_CH; c++) begin
      bus.req[c] = req_v[c];
      bus.gnt[c] = gnt_v[c];
    end
    if (vld && op == PERF_OP_CLEAR) begin
      m_state = 0;
      for (int i = 0; i < 5; i++) m_cnt[i] = 0;
    end else if (vld && op == PERF_OP_START && m_state != 1) begin
      m_state = 1; m_ch = ch; m_pe = pe; m_win = win;
      for (int i = 0; i < 5; i++) m_cnt[i] = 0;
    end else if (m_state == 1) begin
      if (vld && op == PERF_OP_STOP) begin
        m_state = 2;
      end else begin
        m_cnt[0] += longint'(req_v[m_ch][m_pe]);
        m_cnt[1] += longint'(gnt_v[m_ch][m_pe]);
        m_cnt[2] += longint'(req_v[m_ch][m_pe] & ~gnt_v[m_ch][m_pe]);
        m_cnt[3] += longint'($countones(gnt_v[m_ch]));
        if (m_win != 0 && m_cnt[4] == longint'(m_win) - 1) m_state = 2;
        m_cnt[4] += 1;
      end
    end
    m_vld = vld && (op == PERF_OP_READ);
    if (m_vld) begin
      m_out  = word_exp(word, 32);
      m_out8 = word_exp(word, 8);
    end
    @(posedge clk);
    #1;
    check("out_vld", bus.out_vld, m_vld);
    check("out", bus.out, m_out);
    check("out8", bus8.out, m_out8);
    check("busy", bus.busy, m_state == 1);
    check("done", bus.done, m_state == 2);
  endtask

  task automatic idle();
    step(1'b0, PERF_OP_NOP, 0, 0, 0, 0);
  endtask

  task automatic read(input int unsigned word);
    step(1'b1, PERF_OP_READ, 0, 0, 0, word);
  endtask

  task automatic randomize_vectors();
    for (int c = 0; c < N_CH; c++) begin
      req_v[c] = {$urandom, $urandom};
      gnt_v[c] = {$urandom, $urandom};
    end
  endtask

  initial begin
    perf_op_e    op;
    int unsigned r;
    logic [DATA_L-1:0] raw0;

    rst = 1'b0;
    bus.cmd_vld = 1'b0; bus.cmd_op = PERF_OP_NOP; bus.cmd_ch = '0; bus.cmd_pe = '0;
    bus.cmd_win = '0; bus.cmd_word = '0; bus.req = '0; bus.gnt = '0;
    for (int c = 0; c < N_CH; c++) begin req_v[c] = '0; gnt_v[c] = '0; end
    model_reset();
    #12;
    check("rst_out", bus.out, 0);
    check("rst_vld", bus.out_vld, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    @(negedge clk);
    rst = 1'b1;
    read(5);
    check("rst_status", bus.out, 0);

    // 1: req held high on ch0/pe3, grant alternating, 10-sample window.
    randomize_vectors();
    step(1'b1, PERF_OP_START, 0, 3, 10, 0);
    for (int i = 0; i < 10; i++) begin
      req_v[0][3] = 1'b1;
      gnt_v[0][3] = (i % 2 == 0);
      idle();
    end
    check("t1_done", bus.done, 1);
    read(0); check("t1_req", bus.out, 10);
    read(1); check("t1_gnt", bus.out, 5);
    read(2); check("t1_stall", bus.out, 5);
    read(4); check("t1_cyc", bus.out, 10);

    // 2: all grants on ch4, 4-sample window; done rises right after the 4th sample.
    gnt_v[4] = '1;
    step(1'b1, PERF_OP_START, 4, 0, 4, 0);
    for (int i = 0; i < 3; i++) idle();
    check("t2_done_pre", bus.done, 0);
    idle();
    check("t2_done_post", bus.done, 1);
    read(3); check("t2_agg", bus.out, 4 * N_PE);

    // 3: free-run, STOP after 7 sampled cycles, counters then frozen.
    step(1'b1, PERF_OP_START, 1, 10, 0, 0);
    for (int i = 0; i < 7; i++) begin randomize_vectors(); idle(); end
    step(1'b1, PERF_OP_STOP, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin randomize_vectors(); idle(); end
    read(4); check("t3_cyc", bus.out, 7);
    for (int w = 0; w < 6; w++) read(w);

    // 4: 300 request cycles wrap (or saturate) the 8-bit build.
    for (int c = 0; c < N_CH; c++) begin req_v[c] = '0; gnt_v[c] = '0; end
    req_v[0][0] = 1'b1;
    step(1'b1, PERF_OP_START, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) idle();
    step(1'b1, PERF_OP_STOP, 0, 0, 0, 0);
    read(0);
`ifdef IO_PERF_MONITOR_SATURATE_EN
    check("t4_req8", bus8.out, 255);
`else
    check("t4_req8", bus8.out, 44);
`endif
    check("t4_req32", bus.out, 300);
    read(5); check("t4_ovf0", bus8.out[2], 1);

    // 5: live READ during RUN, then CLEAR mid-RUN.
    step(1'b1, PERF_OP_START, 2, 5, 0, 0);
    for (int i = 0; i < 6; i++) begin randomize_vectors(); idle(); end
    randomize_vectors();
    read(2);
    randomize_vectors();
    idle();
    step(1'b1, PERF_OP_CLEAR, 0, 0, 0, 0);
    check("t5_busy", bus.busy, 0);
    read(5); check("t5_status", bus.out, 0);

    // Randomized command stream.
    for (int i = 0; i < 500; i++) begin
      randomize_vectors();
      r  = $urandom_range(0, 99);
      op = perf_op_e'($urandom_range(0, 4));
      if (r < 65)      step(1'b0, op, 0, 0, 0, 0);
      else if (r < 80) step(1'b1, PERF_OP_READ, 0, 0, 0, $urandom_range(0, 9));
      else if (r < 90) step(1'b1, PERF_OP_START, $urandom_range(0, 4), $urandom_range(0, 63),
                            $urandom_range(0, 20), 0);
      else if (r < 96) step(1'b1, PERF_OP_STOP, 0, 0, 0, 0);
      else             step(1'b1, PERF_OP_CLEAR, 0, 0, 0, 0);
    end

    // 6: asynchronous reset mid-RUN, then raw word readout.
    step(1'b1, PERF_OP_START, 2, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin randomize_vectors(); idle(); end
    read(1);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("t6_out", bus.out, 0);
    check("t6_vld", bus.out_vld, 0);
    check("t6_busy", bus.busy, 0);
    check("t6_done", bus.done, 0);
    check("t6_out8", bus8.out, 0);
    @(negedge clk);
    rst = 1'b1;
    randomize_vectors();
    raw0 = req_v[0][31:0];
    read(6); check("t6_raw", bus.out, raw0);
    read(7);
    read(8); check("t6_oob", bus.out, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
